// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports plus the memory-side bus of dm_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dm_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [3:0]        be0;
  logic [31:0]       wdata0;
  logic              ack0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [3:0]        be1;
  logic [31:0]       wdata1;
  logic              ack1;

  logic [31:0]       rdata;
  logic              busy;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_we;
  logic [31:0]       mem_dout;

  modport slave (
    input  req0, we0, addr0, be0, wdata0,
    input  req1, we1, addr1, be1, wdata1,
    input  mem_dout,
    output ack0, ack1, rdata, busy,
    output mem_addr, mem_din, mem_we
  );

  modport master (
    output req0, we0, addr0, be0, wdata0,
    output req1, we1, addr1, be1, wdata1,
    output mem_dout,
    input  ack0, ack1, rdata, busy,
    input  mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin two-port arbiter for the data memory; turns byte-enabled
// partial stores into read-modify-write sequences over a full-word memory.
module dm_arbiter #(
  parameter int ADDR_W  = 12,
  parameter bit RR_INIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              port_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf_q;

  logic              grant_valid;
  logic              grant_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata;
  logic              partial_q;
  logic [31:0]       merged;

  // On a tie the port that did not win last time is served, so continuous
  // requesters strictly alternate.
  assign grant_valid = bus.req0 | bus.req1;
  assign grant_port  = (bus.req0 & bus.req1) ? ~last_grant_q : bus.req1;

  assign sel_we    = grant_port ? bus.we1    : bus.we0;
  assign sel_addr  = grant_port ? bus.addr1  : bus.addr0;
  assign sel_be    = grant_port ? bus.be1    : bus.be0;
  assign sel_wdata = grant_port ? bus.wdata1 : bus.wdata0;

  assign partial_q = we_q && (be_q != 4'b0000) && (be_q != 4'b1111);

  // NOTE: state_t has a reset branch so the async rst_n clears it; the
  // sequential blocks use <= so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid)
          state_d = (sel_we && sel_be == 4'b1111) ? WRITE : READ;
      end
      READ:    state_d = partial_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= RR_INIT;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= 4'b0000;
      wdata_q      <= '0;
      rbuf_q       <= '0;
    end else begin
      if (state_q == IDLE && grant_valid) begin
        last_grant_q <= grant_port;
        port_q       <= grant_port;
        we_q         <= sel_we;
        addr_q       <= {sel_addr[ADDR_W-1:2], 2'b00};
        be_q         <= sel_be;
        wdata_q      <= sel_wdata;
      end
      if (state_q == READ)
        rbuf_q <= bus.mem_dout;
    end
  end

  // Byte-lane merge of new data over the word fetched in READ.
  always_comb begin
    merged = rbuf_q;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Outputs come from state and registers only, so mem_we follows the
  // asynchronous reset immediately.
  assign bus.mem_we   = (state_q == WRITE);
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = (state_q == WRITE) ? merged : 32'h0;
  assign bus.rdata    = rbuf_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.ack0     = (state_q == RESP) && !port_q;
  assign bus.ack1     = (state_q == RESP) &&  port_q;

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-port arbiter and sequencer in front of the word-wide data memory (12-bit byte address, 32-bit word, synchronous write, combinational read). It shares the memory between the CPU data port (port 0) and the debug/loader port (port 1) with round-robin arbitration. It converts byte-enabled partial stores into read-modify-write sequences, because the memory only accepts full-word writes.

Parameters:
ADDR_W, 12, byte-address width of the memory; also the width of both request address ports.
RR_INIT, 1, reset value of last_grant; with 1, port 0 wins the first tie.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  port 0 (CPU) request; held until ack0
we0  input  1  port 0 write (1) / read (0)
addr0  input  ADDR_W  port 0 byte address; bits [1:0] ignored
be0  input  4  port 0 byte enables; be[i] covers bits [8i+7:8i]
wdata0  input  32  port 0 write data, byte-lane aligned
ack0  output  1  one-cycle completion pulse for port 0
req1, we1, addr1, be1, wdata1, ack1  same as port 0, for port 1
rdata  output  32  word read (or pre-write word); valid while ack0/ack1 high
busy  output  1  high whenever state != IDLE
mem_addr  output  ADDR_W  to memory addr; bits [1:0] always 0
mem_din  output  32  to memory din
mem_we  output  1  to memory we
mem_dout  input  32  from memory dout (combinational)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; last_grant=RR_INIT; ack0=ack1=0; mem_we=0; mem_addr=0; mem_din=0; rdata=0; busy=0; all latched request registers cleared. mem_we drops immediately, not at the next edge.
- FSM states: IDLE, READ, WRITE, RESP. All outputs are registered or decoded from state only; no combinational path from req* to mem_*.
- IDLE, arbitration at the rising edge:
  - Only one req high: grant that port.
  - Both high: grant !last_grant.
  - On grant: latch port, we, {addr[ADDR_W-1:2],2'b00}, be, wdata; update last_grant.
- IDLE next state:
  - we=1 and be=4'b1111: WRITE.
  - Any other grant (read, partial write, or we=1 with be=0): READ.
  - No request: stay in IDLE.
- READ (1 cycle):
  - mem_addr = latched address; mem_we=0.
  - At the edge, capture mem_dout into rbuf and rdata.
  - Next state: WRITE if we=1 and be is neither 0 nor 1111; otherwise RESP.
- WRITE (1 cycle):
  - mem_we=1; mem_addr = latched address.
  - mem_din = merged word: byte i = wdata byte i if be[i], else rbuf byte i. For be=1111 the merge takes wdata only.
  - Next state: RESP.
  - For a full write, rdata holds the last captured value.
- RESP (1 cycle): ack of the granted port = 1, the other ack = 0; mem_we=0; next state IDLE.
- Latency from the grant edge to ack high:
  - read and we=1/be=0: 2 cycles (READ, RESP)
  - full write: 2 cycles (WRITE, RESP)
  - partial write: 3 cycles (READ, WRITE, RESP)
  - Each access occupies the memory for 3 or 4 cycles including IDLE.
- Handshake rules:
  - Requester holds req, we, addr, be and wdata stable until it samples ack.
  - It drops req, or presents a new request, at the same edge that ends RESP.
  - Inputs are sampled only in IDLE; changes at any other time are ignored.
- we=1 with be=0: no memory write; acked normally; rdata = current word.
- Starvation bound: with both ports continuously requesting, grants strictly alternate.
- Reset mid-operation: any state returns to IDLE; an in-flight WRITE is abandoned (mem_we=0 at once); no ack is issued; memory contents are whatever the last completed edge wrote.

Test Plan:
- Port 0 full write addr=0x010 wdata=0xDEADBEEF be=1111, then read 0x010 -> mem_we high exactly 1 cycle; ack0 2 cycles after each grant edge; rdata=0xDEADBEEF; ack1 never high.
- Memory word 0x11223344 at 0x020; port 1 writes be=0010 wdata=0x0000AA00 -> READ, WRITE, RESP sequence; mem_din=0x1122AA44; ack1 3 cycles after grant; subsequent read returns 0x1122AA44.
- req0 and req1 both held high for 4 accesses from reset -> grant order 0,1,0,1; ack pulses never overlap; busy low only one cycle between accesses.
- Misaligned addr0=0x033 read -> mem_addr=0x030; returns the word at 0x030.
- Write with be=0000 to a word holding 0x55AA55AA -> mem_we stays 0 throughout; ack issued; rdata=0x55AA55AA.
- rst_n pulsed low during WRITE of a partial store -> mem_we falls asynchronously; state=IDLE; no ack; after release, the next tie grants port 0; target word unchanged.
